// File: rtl/cam_tx_pkg.sv
// Shared types and default constants for the camera serial transmitter.
// Optional parity framing is enabled by defining CAM_TX_PARITY_EN.
package cam_tx_pkg;

  localparam int PIX_W        = 8;
  localparam int ROW_PIX      = 26;
  localparam int ROWS         = 26;
  localparam int CLKS_PER_BIT = 425;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3
`ifdef CAM_TX_PARITY_EN
    , ST_PARITY = 3'd4
`endif
  } state_t;

endpackage

// File: rtl/cam_tx_bit_timer.sv
// Bit-period down-counter: load starts a CLKS_PER_BIT-cycle bit, tick marks its
// final cycle and pre_tick the cycle before it.
module cam_tx_bit_timer #(
  parameter int CLKS_PER_BIT = 425
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic tick,
  output logic pre_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CNT_W-1:0] cnt;

  // Reload at every bit boundary, otherwise count down and park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(CLKS_PER_BIT - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end else begin
      cnt <= cnt;
    end
  end

  assign tick     = (cnt == '0);
  assign pre_tick = (cnt == CNT_W'(1));

endmodule

// File: rtl/cam_serial_tx.sv
// Row-at-a-time serial transmitter: start 1, PIX_W data bits MSB first, stop 0.
// Define CAM_TX_PARITY_EN to insert an even-parity bit before each stop bit.
module cam_serial_tx #(
  parameter int PIX_W        = cam_tx_pkg::PIX_W,
  parameter int ROW_PIX      = cam_tx_pkg::ROW_PIX,
  parameter int ROWS         = cam_tx_pkg::ROWS,
  parameter int CLKS_PER_BIT = cam_tx_pkg::CLKS_PER_BIT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [ROW_PIX*PIX_W-1:0] row_data,
  input  logic                     row_valid,
  output logic                     row_ready,
  output logic                     cam_data,
  output logic                     frame_start,
  output logic                     row_done,
  output logic                     frame_done,
  output logic                     busy
);

  import cam_tx_pkg::*;

  localparam int ROW_W     = ROW_PIX * PIX_W;
  localparam int PIX_CNT_W = (ROW_PIX > 2) ? $clog2(ROW_PIX) : 1;
  localparam int BIT_CNT_W = (PIX_W > 2) ? $clog2(PIX_W) : 1;
  localparam int ROW_CNT_W = (ROWS > 2) ? $clog2(ROWS) : 1;

  state_t               state;
  logic [ROW_W-1:0]     row_lat;
  logic [PIX_CNT_W-1:0] pix_cnt;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [ROW_CNT_W-1:0] row_cnt;
  logic [PIX_W-1:0]     data_sr;
  logic [PIX_W-1:0]     cur_pix;
  logic                 accept;
  logic                 load;
  logic                 tick;
  logic                 pre_tick;
  logic                 last_pix;
`ifdef CAM_TX_PARITY_EN
  logic                 par_bit;
`endif

  function automatic logic [PIX_W-1:0] pick_pixel(input logic [ROW_W-1:0] row,
                                                 input logic [PIX_CNT_W-1:0] k);
    logic [ROW_W-1:0] sh;
    sh = row << (int'(k) * PIX_W);
    return sh[ROW_W-1 -: PIX_W];
  endfunction

  function automatic logic even_parity(input logic [PIX_W-1:0] pix);
    return ^pix;
  endfunction

  // Gated by rst_n so the handshake stays quiet while reset is held.
  assign row_ready = rst_n && (state == ST_IDLE) && en;
  assign accept    = row_ready && row_valid;
  assign load      = (state == ST_IDLE) ? accept : tick;
  assign cur_pix   = pick_pixel(row_lat, pix_cnt);
  assign last_pix  = (pix_cnt == PIX_CNT_W'(ROW_PIX - 1));

  cam_tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .tick    (tick),
    .pre_tick(pre_tick)
  );

  // Framing FSM; every output is registered and set one bit-boundary ahead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      row_lat     <= '0;
      pix_cnt     <= '0;
      bit_cnt     <= '0;
      row_cnt     <= '0;
      data_sr     <= '0;
      cam_data    <= 1'b0;
      frame_start <= 1'b0;
      row_done    <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
`ifdef CAM_TX_PARITY_EN
      par_bit     <= 1'b0;
`endif
    end else begin
      frame_start <= 1'b0;
      row_done    <= 1'b0;
      frame_done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            row_lat     <= row_data;
            pix_cnt     <= '0;
            state       <= ST_START;
            cam_data    <= 1'b1;
            busy        <= 1'b1;
            frame_start <= (row_cnt == '0);
          end
        end
        ST_START: begin
          if (tick) begin
            state    <= ST_DATA;
            cam_data <= cur_pix[PIX_W-1];
            data_sr  <= cur_pix << 1;
            bit_cnt  <= '0;
`ifdef CAM_TX_PARITY_EN
            par_bit  <= even_parity(cur_pix);
`endif
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_cnt == BIT_CNT_W'(PIX_W - 1)) begin
`ifdef CAM_TX_PARITY_EN
              state    <= ST_PARITY;
              cam_data <= par_bit;
`else
              state    <= ST_STOP;
              cam_data <= 1'b0;
`endif
            end else begin
              cam_data <= data_sr[PIX_W-1];
              data_sr  <= data_sr << 1;
              bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
            end
          end
        end
`ifdef CAM_TX_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            state    <= ST_STOP;
            cam_data <= 1'b0;
          end
        end
`endif
        ST_STOP: begin
          if (pre_tick && last_pix) begin
            row_done   <= 1'b1;
            frame_done <= (row_cnt == ROW_CNT_W'(ROWS - 1));
          end
          if (tick) begin
            if (last_pix) begin
              state   <= ST_IDLE;
              busy    <= 1'b0;
              row_cnt <= (row_cnt == ROW_CNT_W'(ROWS - 1)) ? '0 : row_cnt + ROW_CNT_W'(1);
            end else begin
              state    <= ST_START;
              cam_data <= 1'b1;
              pix_cnt  <= pix_cnt + PIX_CNT_W'(1);
            end
          end
        end
        default: begin
          state    <= ST_IDLE;
          cam_data <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cam_serial_tx.sv
// Randomized bench for cam_serial_tx against a queue-based per-cycle waveform model.
// Follows CAM_TX_PARITY_EN when defined for the build.
module tb_cam_serial_tx;

  localparam int PIX_W   = 8;
  localparam int ROW_PIX = 26;
  localparam int ROWS    = 4;
  localparam int CPB     = 4;
  localparam int ROW_W   = ROW_PIX * PIX_W;
`ifdef CAM_TX_PARITY_EN
  localparam int         PIX_BITS   = 11;
  localparam int         ROW_LEN    = 1144;
  localparam logic [7:0] DIR_PIX    = 8'h07;
  localparam logic [10:0] DIR_FRAME = 11'b10000011110;
`else
  localparam int         PIX_BITS   = 10;
  localparam int         ROW_LEN    = 1040;
  localparam logic [7:0] DIR_PIX    = 8'hA5;
  localparam logic [10:0] DIR_FRAME = 11'b01101001010;
`endif

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [ROW_W-1:0] row_data;
  logic             row_valid;
  logic             row_ready;
  logic             cam_data;
  logic             frame_start;
  logic             row_done;
  logic             frame_done;
  logic             busy;

  cam_serial_tx #(
    .PIX_W(PIX_W), .ROW_PIX(ROW_PIX), .ROWS(ROWS), .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .row_data(row_data), .row_valid(row_valid),
    .row_ready(row_ready), .cam_data(cam_data), .frame_start(frame_start),
    .row_done(row_done), .frame_done(frame_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Model: one entry per future cycle of the current row's expected outputs.
  typedef struct packed {
    logic cam;
    logic fs;
    logic rd;
    logic fd;
  } exp_t;

  exp_t q[$];
  int   row_cnt_m = 0;

  initial forever begin
    bit               idle_now;
    logic [PIX_W-1:0] pix;
    logic             bits[$];
    exp_t             e;
    int               n;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      q.delete();
      row_cnt_m = 0;
    end else begin
      idle_now = (q.size() == 0);
      if (!idle_now) void'(q.pop_front());
      if (idle_now && en && row_valid) begin
        bits.delete();
        for (int p = 0; p < ROW_PIX; p++) begin
          pix = row_data[ROW_W-1-p*PIX_W -: PIX_W];
          bits.push_back(1'b1);
          for (int b = PIX_W - 1; b >= 0; b--) bits.push_back(pix[b]);
`ifdef CAM_TX_PARITY_EN
          bits.push_back(^pix);
`endif
          bits.push_back(1'b0);
        end
        n = bits.size() * CPB;
        for (int i = 0; i < n; i++) begin
          e.cam = bits[i / CPB];
          e.fs  = (i == 0) && (row_cnt_m == 0);
          e.rd  = (i == n - 1);
          e.fd  = (i == n - 1) && (row_cnt_m == ROWS - 1);
          q.push_back(e);
        end
        row_cnt_m = (row_cnt_m + 1) % ROWS;
      end
    end
  end

  // Every cycle, all outputs against the model.
  initial forever begin
    exp_t e;
    @(negedge clk);
    e = (q.size() > 0) ? q[0] : exp_t'(4'b0000);
    chk("cam_data", cam_data, e.cam);
    chk("frame_start", frame_start, e.fs);
    chk("row_done", row_done, e.rd);
    chk("frame_done", frame_done, e.fd);
    chk("busy", busy, q.size() > 0);
    chk("row_ready", row_ready, rst_n && en && (q.size() == 0));
  end

  function automatic logic [ROW_W-1:0] rand_row();
    logic [255:0] t;
    for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom();
    return t[ROW_W-1:0];
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3 * ROW_LEN; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
    chk(name, ok, 1'b1);
  endtask

  initial begin
    logic [10:0] obs;
    bit          ok;
    int          s0;
    int          fs_n, rd_n, fd_n;
    int          rd_c[2];

    rst_n = 1'b0; en = 1'b0; row_valid = 1'b0; row_data = '0;
    step(3);
    rst_n = 1'b1;
    en    = 1'b1;
    step(20);
    chk("idle_row_ready", row_ready, 1'b1);
    chk("idle_cam_data", cam_data, 1'b0);
    chk("idle_busy", busy, 1'b0);

    // Directed pixel 0, rest zero: framing, frame_start and row length.
    row_data = '0;
    row_data[ROW_W-1 -: PIX_W] = DIR_PIX;
    row_valid = 1'b1;
    step(1);
    row_valid = 1'b0;
    @(negedge clk);
    chk("first_frame_start", frame_start, 1'b1);
    s0  = cyc;
    obs = '0;
    @(negedge clk);
    obs[PIX_BITS-1] = cam_data;
    for (int b = 1; b < PIX_BITS; b++) begin
      repeat (CPB) @(negedge clk);
      obs[PIX_BITS-1-b] = cam_data;
    end
    chk("pixel0_frame", obs, DIR_FRAME);
    ok = 1'b0;
    for (int i = 0; i < 2 * ROW_LEN; i++) begin
      @(negedge clk);
      if (row_done) begin
        ok = 1'b1;
        break;
      end
    end
    chk("row_done_seen", ok, 1'b1);
    chk("row_len", cyc - s0 + 1, ROW_LEN);
    step(1);

    // Random handshakes, en drops and row_data churn while busy.
    for (int i = 0; i < 12000; i++) begin
      en        = ($urandom_range(0, 7) != 0);
      row_valid = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) row_data = rand_row();
      step(1);
    end
    row_valid = 1'b0;
    en        = 1'b1;
    wait_idle("drain_random");

    // Back-to-back stream of ROWS+1 rows from a fresh frame.
    rst_n = 1'b0;
    step(2);
    rst_n     = 1'b1;
    row_data  = rand_row();
    row_valid = 1'b1;
    fs_n = 0; rd_n = 0; fd_n = 0; rd_c[0] = 0; rd_c[1] = 0;
    for (int i = 0; i < (ROWS + 1) * (ROW_LEN + 2) + 50; i++) begin
      @(negedge clk);
      if (frame_start) fs_n++;
      if (frame_done) fd_n++;
      if (row_done) begin
        if (rd_n < 2) rd_c[rd_n] = cyc;
        rd_n++;
        if (rd_n == ROWS + 1) break;
      end
    end
    row_valid = 1'b0;
    chk("stream_frame_starts", fs_n, 2);
    chk("stream_row_dones", rd_n, ROWS + 1);
    chk("stream_frame_dones", fd_n, 1);
    chk("stream_row_period", rd_c[1] - rd_c[0], ROW_LEN + 1);
    step(1);
    wait_idle("drain_stream");

    // Reset mid-pixel with the row counter away from zero.
    row_data  = rand_row();
    row_valid = 1'b1;
    step(1);
    row_valid = 1'b0;
    step(CPB * PIX_BITS * 3 + CPB * 2 + 1);
    chk("busy_before_reset", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("reset_cam_data", cam_data, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_row_ready", row_ready, 1'b0);
    step(2);
    rst_n     = 1'b1;
    row_valid = 1'b1;
    step(1);
    row_valid = 1'b0;
    @(negedge clk);
    chk("post_reset_frame_start", frame_start, 1'b1);
    step(1);

    en = 1'b0;
    wait_idle("drain_final");
    step(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
